// File: rtl/led_pattern_gen_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_t;

    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_freq_khz);
        return ms * clk_freq_khz;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write port and LED status outputs of the pattern generator.
interface led_pattern_gen_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned BURST_W  = 8,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    import led_pattern_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    led_mode_t           cfg_mode;
    logic [PERIOD_W-1:0] cfg_half_ms;
    logic [BURST_W-1:0]  cfg_burst;
    logic [CHANNELS-1:0] led;
    logic [CHANNELS-1:0] busy;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_half_ms, cfg_burst,
        input  cfg_ready, led, busy
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_half_ms, cfg_burst,
        output cfg_ready, led, busy
    );

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: OFF/ON/BLINK/BURST pattern advanced by the shared ms tick.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned BURST_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ms_tick_i,
    input  logic                apply_i,
    input  led_mode_t           mode_i,
    input  logic [PERIOD_W-1:0] half_i,
    input  logic [BURST_W-1:0]  burst_i,
    output logic                led_o,
    output logic                busy_o
);

    led_mode_t           mode_q, mode_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [BURST_W-1:0]  rem_q, rem_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;

    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        led_d  = led_q;
        busy_d = busy_q;
        // Apply wins over a coincident tick so the new pattern starts from a clean phase.
        if (apply_i) begin
            cnt_d  = '0;
            half_d = (half_i == '0) ? PERIOD_W'(1) : half_i;
            rem_d  = burst_i;
            busy_d = 1'b0;
            unique case (mode_i)
                LED_OFF: begin
                    mode_d = LED_OFF;
                    led_d  = 1'b0;
                end
                LED_ON: begin
                    mode_d = LED_ON;
                    led_d  = 1'b1;
                end
                LED_BLINK: begin
                    mode_d = LED_BLINK;
                    led_d  = 1'b1;
                end
                LED_BURST: begin
                    if (burst_i != '0) begin
                        mode_d = LED_BURST;
                        led_d  = 1'b1;
                        busy_d = 1'b1;
                    end else begin
                        mode_d = LED_OFF;
                        led_d  = 1'b0;
                    end
                end
            endcase
        end else if (ms_tick_i && (mode_q == LED_BLINK || mode_q == LED_BURST)) begin
            if (cnt_q == half_q - 1'b1) begin
                cnt_d = '0;
                led_d = !led_q;
                if (mode_q == LED_BURST && led_q) begin
                    rem_d = rem_q - 1'b1;
                    // Last falling edge ends the burst; no trailing off-phase.
                    if (rem_q == BURST_W'(1)) begin
                        mode_d = LED_OFF;
                        busy_d = 1'b0;
                        led_d  = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= LED_OFF;
            half_q <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: ms prescaler, one-entry config staging, channel array.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CLK_FREQ_KHz = 50000,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned BURST_W      = 8,
    parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic              clk,
    input logic              rst,
    led_pattern_gen_if.slave cfg
);

    localparam int unsigned     PreW   = (CLK_FREQ_KHz > 1) ? $clog2(CLK_FREQ_KHz) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_FREQ_KHz - 1);

    logic [PreW-1:0] presc_q, presc_d;
    logic            ms_tick;

    always_comb begin
        ms_tick = (presc_q == PreMax);
        presc_d = ms_tick ? '0 : presc_q + 1'b1;
    end

    logic                stage_valid_q, stage_valid_d;
    logic [CH_W-1:0]     stage_ch_q, stage_ch_d;
    led_mode_t           stage_mode_q, stage_mode_d;
    logic [PERIOD_W-1:0] stage_half_q, stage_half_d;
    logic [BURST_W-1:0]  stage_burst_q, stage_burst_d;
    logic                accept;

    assign cfg.cfg_ready = !rst && !stage_valid_q;

    // Staging holds a write for exactly one cycle, then it is applied and freed.
    always_comb begin
        accept        = cfg.cfg_valid && cfg.cfg_ready;
        stage_valid_d = accept;
        stage_ch_d    = stage_ch_q;
        stage_mode_d  = stage_mode_q;
        stage_half_d  = stage_half_q;
        stage_burst_d = stage_burst_q;
        if (accept) begin
            stage_ch_d    = cfg.cfg_ch;
            stage_mode_d  = cfg.cfg_mode;
            stage_half_d  = cfg.cfg_half_ms;
            stage_burst_d = cfg.cfg_burst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_ch_q    <= '0;
            stage_mode_q  <= LED_OFF;
            stage_half_q  <= '0;
            stage_burst_q <= '0;
        end else begin
            presc_q       <= presc_d;
            stage_valid_q <= stage_valid_d;
            stage_ch_q    <= stage_ch_d;
            stage_mode_q  <= stage_mode_d;
            stage_half_q  <= stage_half_d;
            stage_burst_q <= stage_burst_d;
        end
    end

    logic [CHANNELS-1:0] led_w;
    logic [CHANNELS-1:0] busy_w;

    // Out-of-range indices match no channel, so such writes are silently dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic apply;
        assign apply = stage_valid_q && (stage_ch_q == CH_W'(i));

        led_channel #(
            .PERIOD_W(PERIOD_W),
            .BURST_W (BURST_W)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .ms_tick_i(ms_tick),
            .apply_i  (apply),
            .mode_i   (stage_mode_q),
            .half_i   (stage_half_q),
            .burst_i  (stage_burst_q),
            .led_o    (led_w[i]),
            .busy_o   (busy_w[i])
        );
    end

    assign cfg.led  = led_w;
    assign cfg.busy = busy_w;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed plus randomized bench for led_pattern_gen against a tick-count reference model.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int unsigned K   = 4;
    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned CHW = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_pattern_gen_if #(.CHANNELS(NCH), .PERIOD_W(PW), .BURST_W(BW), .CH_W(CHW)) bus ();

    led_pattern_gen #(
        .CLK_FREQ_KHz(K),
        .CHANNELS    (NCH),
        .PERIOD_W    (PW),
        .BURST_W     (BW),
        .CH_W        (CHW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each channel remembers its pattern and how many ms ticks
    // have elapsed since it was applied; outputs follow by division.
    int m_presc = 0;
    bit m_sv    = 1'b0;
    int m_sch, m_smode, m_shalf, m_sburst;
    int m_mode[NCH];
    int m_half[NCH];
    int m_burst[NCH];
    int m_ticks[NCH];

    function automatic bit m_busy(input int i);
        return (m_mode[i] == 3) && (m_ticks[i] < (2 * m_burst[i] - 1) * m_half[i]);
    endfunction

    function automatic bit m_led(input int i);
        case (m_mode[i])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((m_ticks[i] / m_half[i]) % 2) == 0;
            default: return m_busy(i) && (((m_ticks[i] / m_half[i]) % 2) == 0);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit tick;
        bit ready;
        logic [NCH-1:0] exp_led;
        logic [NCH-1:0] exp_busy;
        ready = !rst && !m_sv;
        if (rst) begin
            m_presc = 0;
            m_sv    = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i]  = 0;
                m_half[i]  = 1;
                m_burst[i] = 0;
                m_ticks[i] = 0;
            end
        end else begin
            tick    = (m_presc == K - 1);
            m_presc = (m_presc + 1) % K;
            for (int i = 0; i < NCH; i++) begin
                if (m_sv && m_sch == i) begin
                    m_mode[i]  = (m_smode == 3 && m_sburst == 0) ? 0 : m_smode;
                    m_half[i]  = (m_shalf == 0) ? 1 : m_shalf;
                    m_burst[i] = m_sburst;
                    m_ticks[i] = 0;
                end else if (tick && m_mode[i] >= 2) begin
                    m_ticks[i]++;
                end
            end
            m_sv = bus.cfg_valid && ready;
            if (m_sv) begin
                m_sch    = int'(bus.cfg_ch);
                m_smode  = int'(bus.cfg_mode);
                m_shalf  = int'(bus.cfg_half_ms);
                m_sburst = int'(bus.cfg_burst);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            exp_led[i]  = m_led(i);
            exp_busy[i] = m_busy(i);
        end
        check("led", 32'(bus.led), 32'(exp_led));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(!rst && !m_sv));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Presents a write and steps until the model says it was accepted (bounded).
    task automatic write(input int ch, input int mode, input int half, input int burst);
        bit done = 1'b0;
        bus.cfg_valid   = 1'b1;
        bus.cfg_ch      = CHW'(ch);
        bus.cfg_mode    = led_mode_t'(mode);
        bus.cfg_half_ms = PW'(half);
        bus.cfg_burst   = BW'(burst);
        for (int k = 0; k < 8 && !done; k++) begin
            done = !rst && !m_sv;
            step();
        end
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        logic prev;
        logic [NCH-1:0] led_snap;

        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_ch      = '0;
        bus.cfg_mode    = LED_OFF;
        bus.cfg_half_ms = '0;
        bus.cfg_burst   = '0;
        #1;
        check("ready_in_reset_pre", 32'(bus.cfg_ready), 32'd0);

        // 1. Reset
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_led", 32'(bus.led), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_ready", 32'(bus.cfg_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.cfg_ready), 32'd1);

        // 2. ch0 BLINK half=2
        write(0, 2, 2, 0);
        check("blink_not_yet", 32'(bus.led[0]), 32'd0);
        step();
        check("blink_led0_on", 32'(bus.led[0]), 32'd1);
        run(40);
        check("blink_others_off", 32'(bus.led[3:1]), 32'd0);

        // 3. ch1 BURST half=1 burst=3: count rising edges of led[1]
        write(1, 3, 1, 3);
        step();
        check("burst_busy1", 32'(bus.busy[1]), 32'd1);
        pulses = 1;
        prev   = bus.led[1];
        for (int k = 0; k < 50; k++) begin
            step();
            if (bus.led[1] && !prev) pulses++;
            prev = bus.led[1];
        end
        check("burst_pulses", 32'(pulses), 32'd3);
        check("burst_done_led", 32'(bus.led[1]), 32'd0);
        check("burst_done_busy", 32'(bus.busy[1]), 32'd0);

        // 4. cfg_valid held high: ch2 ON then ch3 ON
        bus.cfg_valid   = 1'b1;
        bus.cfg_ch      = CHW'(2);
        bus.cfg_mode    = LED_ON;
        bus.cfg_half_ms = '0;
        bus.cfg_burst   = '0;
        step();
        check("b2b_ready_T", 32'(bus.cfg_ready), 32'd0);
        check("b2b_led2_T", 32'(bus.led[2]), 32'd0);
        bus.cfg_ch = CHW'(3);
        step();
        check("b2b_led2_T1", 32'(bus.led[2]), 32'd1);
        check("b2b_ready_T1", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        check("b2b_ready_T2", 32'(bus.cfg_ready), 32'd0);
        check("b2b_led3_T2", 32'(bus.led[3]), 32'd0);
        step();
        check("b2b_led3_T3", 32'(bus.led[3]), 32'd1);

        // 5. Override a running burst with ON
        write(1, 3, 3, 5);
        run(10);
        write(1, 1, 0, 0);
        step();
        check("override_led1", 32'(bus.led[1]), 32'd1);
        check("override_busy1", 32'(bus.busy[1]), 32'd0);
        run(20);

        // 6. half=0, out-of-range channel, reset mid-blink
        write(0, 2, 0, 0);
        run(20);
        led_snap = bus.led;
        write(5, 1, 1, 0);
        step();
        check("bad_ch_led_hi", 32'(bus.led[3:1]), 32'(led_snap[3:1]));
        run(10);
        rst = 1'b1;
        step();
        check("midrst_led", 32'(bus.led), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Randomized writes, gaps and occasional resets
        for (int it = 0; it < 60; it++) begin
            write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run(int'($urandom_range(0, 30)));
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1;
                run(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
        end
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
